// File: rtl/eggtimer_ctrl_pkg.sv
// Shared types and constants for the egg timer controller: FSM states, BCD width,
// seconds wrap value and the last-second detector used by the countdown.
package eggtimer_ctrl_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam int unsigned SEC_WRAP = 59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    // True when the displayed value is 00:01, i.e. the next tick lands on 00:00.
    function automatic logic is_last_second(input logic             min_zero,
                                            input logic [BCD_W-1:0] s_tens,
                                            input logic [BCD_W-1:0] s_ones);
        return min_zero && (s_tens == '0) && (s_ones == BCD_W'(1));
    endfunction

endpackage

// File: rtl/eggtimer_ctrl_bcd_mod_counter.sv
// Two-digit BCD counter that wraps between 00 and MAX in both directions.
// Priority: clr > dec > inc; is_zero reflects the registered digits.
module bcd_mod_counter
    import eggtimer_ctrl_pkg::*;
#(
    parameter int unsigned MAX = SEC_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             is_zero
);

    localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'(MAX / 10);
    localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'(MAX % 10);
    localparam logic [BCD_W-1:0] NINE     = BCD_W'(9);

    logic at_max;

    assign is_zero = (tens == '0) && (ones == '0);
    assign at_max  = (tens == MAX_TENS) && (ones == MAX_ONES);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            tens <= '0;
            ones <= '0;
        end else if (dec) begin
            if (is_zero) begin
                tens <= MAX_TENS;
                ones <= MAX_ONES;
            end else if (ones == '0) begin
                tens <= tens - BCD_W'(1);
                ones <= NINE;
            end else begin
                ones <= ones - BCD_W'(1);
            end
        end else if (inc) begin
            if (at_max) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == NINE) begin
                tens <= tens + BCD_W'(1);
                ones <= '0;
            end else begin
                ones <= ones + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/eggtimer_ctrl.sv
// Egg timer countdown controller: MM:SS in BCD, set/start/pause/clear, alarm at 00:00.
// Optional alarm auto-silence after ALARM_SECS ticks: define EGGTIMER_AUTO_SILENCE_EN.
module eggtimer_ctrl
    import eggtimer_ctrl_pkg::*;
#(
    parameter int unsigned MAX_MIN    = 59,
    parameter int unsigned ALARM_SECS = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             inc_min,
    input  logic             inc_sec,
    output logic             div_reset,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             alarm
);

    if (MAX_MIN < 1 || MAX_MIN > 99 || ALARM_SECS < 1) begin : g_param_check
        $error("eggtimer_ctrl: MAX_MIN must be 1..99 and ALARM_SECS at least 1");
    end

    state_t state, state_nxt;
    logic   sec_zero, min_zero, at_zero, last_sec;
    logic   idle_edit, run_tick;
    logic   silence_done;

    assign at_zero  = sec_zero && min_zero;
    assign last_sec = is_last_second(min_zero, sec_tens, sec_ones);

    // Ticks never swallow a set press in IDLE; only clear/start_stop outrank the incs there.
    assign idle_edit = (state == ST_IDLE) && !clear && !start_stop;
    assign run_tick  = (state == ST_RUN)  && !clear && !start_stop && tick;

    bcd_mod_counter #(.MAX(SEC_WRAP)) u_sec (
        .clk     (clk),
        .reset   (reset),
        .clr     (clear),
        .inc     (idle_edit && inc_sec),
        .dec     (run_tick),
        .tens    (sec_tens),
        .ones    (sec_ones),
        .is_zero (sec_zero)
    );

    bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
        .clk     (clk),
        .reset   (reset),
        .clr     (clear),
        .inc     (idle_edit && inc_min),
        .dec     (run_tick && sec_zero),
        .tens    (min_tens),
        .ones    (min_ones),
        .is_zero (min_zero)
    );

`ifdef EGGTIMER_AUTO_SILENCE_EN
    localparam int unsigned CNT_W = $clog2(ALARM_SECS + 1);
    localparam bit          ALARM_DRIVES_DIV = 1'b1;

    logic [CNT_W-1:0] silence_cnt;

    assign silence_done = tick && (silence_cnt == CNT_W'(ALARM_SECS - 1));

    // Held at zero outside ALARM, so it always starts from zero on entry.
    always_ff @(posedge clk) begin
        if (!reset || state != ST_ALARM) begin
            silence_cnt <= '0;
        end else if (tick) begin
            silence_cnt <= silence_cnt + CNT_W'(1);
        end
    end
`else
    localparam bit ALARM_DRIVES_DIV = 1'b0;

    assign silence_done = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!clear && start_stop && !at_zero) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (clear)                 state_nxt = ST_IDLE;
                else if (start_stop)       state_nxt = ST_PAUSE;
                else if (tick && last_sec) state_nxt = ST_ALARM;
            end
            ST_PAUSE: begin
                if (clear)           state_nxt = ST_IDLE;
                else if (start_stop) state_nxt = ST_RUN;
            end
            ST_ALARM: begin
                if (clear || start_stop || silence_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            alarm     <= 1'b0;
            div_reset <= 1'b1;
        end else begin
            state     <= state_nxt;
            running   <= (state_nxt == ST_RUN);
            alarm     <= (state_nxt == ST_ALARM);
            div_reset <= !((state_nxt == ST_RUN) ||
                           (ALARM_DRIVES_DIV && state_nxt == ST_ALARM));
        end
    end

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Self-checking bench for eggtimer_ctrl: directed scenarios plus randomized traffic
// checked against a minutes/seconds reference model.
module tb_eggtimer_ctrl;

    localparam int unsigned MAX_MIN    = 59;
    localparam int unsigned ALARM_SECS = 30;
`ifdef EGGTIMER_AUTO_SILENCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0, start_stop = 1'b0, clear = 1'b0, inc_min = 1'b0, inc_sec = 1'b0;
    logic       div_reset, running, alarm;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: plain integers; st 0=idle 1=running 2=paused 3=alarm.
    int m_min = 0, m_sec = 0, m_st = 0, m_cnt = 0;

    always #5 clk = ~clk;

    eggtimer_ctrl #(.MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
        .inc_min    (inc_min),
        .inc_sec    (inc_sec),
        .div_reset  (div_reset),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .alarm      (alarm)
    );

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [2:0] flags();
        return {running, alarm, div_reset};
    endfunction

    function automatic logic [15:0] model_digits();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    function automatic logic [2:0] model_flags();
        return {m_st == 1, m_st == 3, !(m_st == 1 || (AUTO && m_st == 3))};
    endfunction

    task automatic model_step(input bit tk, ss, cl, im, is, rs);
        if (!rs) begin
            m_st = 0; m_min = 0; m_sec = 0; m_cnt = 0;
        end else if (cl) begin
            m_st = 0; m_min = 0; m_sec = 0;
        end else if (ss) begin
            case (m_st)
                0: if (m_min != 0 || m_sec != 0) m_st = 1;
                1: m_st = 2;
                2: m_st = 1;
                default: m_st = 0;
            endcase
        end else if (m_st == 0) begin
            if (im) m_min = (m_min == MAX_MIN) ? 0 : m_min + 1;
            if (is) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
        end else if (tk && m_st == 1) begin
            if (m_sec == 0) begin m_min = m_min - 1; m_sec = 59; end
            else m_sec = m_sec - 1;
            if (m_min == 0 && m_sec == 0) begin m_st = 3; m_cnt = 0; end
        end else if (tk && m_st == 3 && AUTO) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == ALARM_SECS) m_st = 0;
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input bit tk, ss, cl, im, is, rs);
        @(negedge clk);
        tick = tk; start_stop = ss; clear = cl; inc_min = im; inc_sec = is; reset = rs;
        @(posedge clk);
        model_step(tk, ss, cl, im, is, rs);
        #1;
        tick = 0; start_stop = 0; clear = 0; inc_min = 0; inc_sec = 0; reset = 1;
    endtask

    task automatic test_reset;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        compared++;
        if (digits() !== 16'h0000 || flags() !== 3'b001) begin
            mismatched++;
            $display("FAIL reset: got %h/%b expected 0000/001", digits(), flags());
        end
    endtask

    task automatic test_set;
        repeat (3) cyc(0, 0, 0, 1, 0, 1);
        repeat (5) cyc(1, 0, 0, 0, 1, 1);
        compared++;
        if (digits() !== 16'h0305 || flags() !== 3'b001) begin
            mismatched++;
            $display("FAIL set: got %h/%b expected 0305/001", digits(), flags());
        end
        cyc(0, 0, 0, 1, 1, 1);
        compared++;
        if (digits() !== 16'h0406) begin
            mismatched++;
            $display("FAIL set_both: got %h expected 0406", digits());
        end
    endtask

    task automatic test_countdown_borrow;
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        compared++;
        if (digits() !== 16'h0100 || flags() !== 3'b100) begin
            mismatched++;
            $display("FAIL start: got %h/%b expected 0100/100", digits(), flags());
        end
        cyc(0, 0, 0, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 1);
        compared++;
        if (digits() !== 16'h0059) begin
            mismatched++;
            $display("FAIL borrow: got %h expected 0059", digits());
        end
        repeat (58) cyc(1, 0, 0, 0, 0, 1);
        compared++;
        if (digits() !== 16'h0001 || flags() !== 3'b100) begin
            mismatched++;
            $display("FAIL count_0001: got %h/%b expected 0001/100", digits(), flags());
        end
        cyc(1, 0, 0, 0, 0, 1);
        compared++;
        if (digits() !== 16'h0000 || flags() !== {2'b01, !AUTO}) begin
            mismatched++;
            $display("FAIL alarm_entry: got %h/%b expected 0000/01%b", digits(), flags(), !AUTO);
        end
        cyc(0, 1, 0, 0, 0, 1);
        compared++;
        if (flags() !== 3'b001) begin
            mismatched++;
            $display("FAIL alarm_stop: got %b expected 001", flags());
        end
    endtask

    task automatic test_pause_resume;
        repeat (10) cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 1);
        compared++;
        if (digits() !== 16'h0010 || flags() !== 3'b001) begin
            mismatched++;
            $display("FAIL pause: got %h/%b expected 0010/001", digits(), flags());
        end
        repeat (5) cyc(1, 0, 0, 1, 1, 1);
        compared++;
        if (digits() !== 16'h0010 || flags() !== 3'b001) begin
            mismatched++;
            $display("FAIL pause_hold: got %h/%b expected 0010/001", digits(), flags());
        end
        cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        compared++;
        if (digits() !== 16'h0009 || flags() !== 3'b100) begin
            mismatched++;
            $display("FAIL resume: got %h/%b expected 0009/100", digits(), flags());
        end
    endtask

    task automatic test_wrap_ignore;
        cyc(0, 0, 1, 0, 0, 1);
        repeat (59) cyc(0, 0, 0, 0, 1, 1);
        compared++;
        if (digits() !== 16'h0059) begin
            mismatched++;
            $display("FAIL sec_59: got %h expected 0059", digits());
        end
        cyc(0, 0, 0, 0, 1, 1);
        compared++;
        if (digits() !== 16'h0000) begin
            mismatched++;
            $display("FAIL sec_wrap: got %h expected 0000", digits());
        end
        repeat (MAX_MIN) cyc(0, 0, 0, 1, 0, 1);
        compared++;
        if (digits() !== 16'h5900) begin
            mismatched++;
            $display("FAIL min_max: got %h expected 5900", digits());
        end
        cyc(0, 0, 0, 1, 0, 1);
        compared++;
        if (digits() !== 16'h0000) begin
            mismatched++;
            $display("FAIL min_wrap: got %h expected 0000", digits());
        end
        cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        compared++;
        if (digits() !== 16'h0000 || flags() !== 3'b001) begin
            mismatched++;
            $display("FAIL start_at_zero: got %h/%b expected 0000/001", digits(), flags());
        end
    endtask

    task automatic test_clear_reset_midrun;
        repeat (2) cyc(0, 0, 0, 1, 0, 1);
        repeat (30) cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 0, 1);
        compared++;
        if (digits() !== 16'h0000 || flags() !== 3'b001) begin
            mismatched++;
            $display("FAIL clear_run: got %h/%b expected 0000/001", digits(), flags());
        end
        repeat (5) cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 1);
        repeat (2) cyc(1, 0, 0, 0, 0, 1);
        compared++;
        if (digits() !== 16'h0003 || flags() !== 3'b100) begin
            mismatched++;
            $display("FAIL restart: got %h/%b expected 0003/100", digits(), flags());
        end
        cyc(1, 0, 0, 0, 0, 0);
        compared++;
        if (digits() !== 16'h0000 || flags() !== 3'b001) begin
            mismatched++;
            $display("FAIL reset_run: got %h/%b expected 0000/001", digits(), flags());
        end
    endtask

    task automatic test_alarm_exit;
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        if (AUTO) begin
            repeat (ALARM_SECS - 1) cyc(1, 0, 0, 0, 0, 1);
            compared++;
            if (flags() !== 3'b010) begin
                mismatched++;
                $display("FAIL silence_before: got %b expected 010", flags());
            end
            cyc(1, 0, 0, 0, 0, 1);
            compared++;
            if (flags() !== 3'b001) begin
                mismatched++;
                $display("FAIL silence_at: got %b expected 001", flags());
            end
        end else begin
            repeat (100) cyc(1, 0, 0, 0, 0, 1);
            compared++;
            if (digits() !== 16'h0000 || flags() !== 3'b011) begin
                mismatched++;
                $display("FAIL alarm_hold: got %h/%b expected 0000/011", digits(), flags());
            end
            cyc(0, 1, 0, 0, 0, 1);
            compared++;
            if (flags() !== 3'b001) begin
                mismatched++;
                $display("FAIL alarm_exit: got %b expected 001", flags());
            end
        end
    endtask

    task automatic test_random;
        int r;
        bit tk, ss, cl, im, is, rs;
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            r  = int'($urandom_range(0, 99));
            tk = bit'($urandom_range(0, 1));
            ss = (r >= 2 && r < 6);
            cl = (r < 2);
            im = (r >= 14 && r < 18);
            is = (r >= 6 && r < 14) || (r >= 16 && r < 18);
            rs = ($urandom_range(0, 499) != 0);
            cyc(tk, ss, cl, im, is, rs);
            compared++;
            if (digits() !== model_digits() || flags() !== model_flags()) begin
                mismatched++;
                $display("FAIL random[%0d]: got %h/%b expected %h/%b", i, digits(), flags(),
                         model_digits(), model_flags());
            end
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_countdown_borrow();
        test_pause_resume();
        test_wrap_ignore();
        test_clear_reset_midrun();
        test_alarm_exit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
